// File: rtl/multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_pkg
// Purpose  : Shared types and constants for the sequential shift-add
//            multiplier: FSM state encoding, default operand width and the
//            iteration-counter width helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package multiplier_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The counter must be able to hold the value DATA_WIDTH itself.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage : multiplier_pkg
`default_nettype wire

// File: rtl/multiplier_if.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_if
// Purpose  : Request/response bundle between a requester and the multiplier.
// Signals  : operand1  multiplicand (unsigned)
//            operand2  multiplier   (unsigned)
//            start     request, level-sampled on each rising edge
//            result    2*DATA_WIDTH product, held until next completion
//            valid     one-cycle completion pulse
// Modports : master (requester), slave (multiplier)
// Revision : 1.0  initial release
// ============================================================================
interface multiplier_if #(
    parameter int DATA_WIDTH = multiplier_pkg::DEFAULT_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]   operand1;
    logic [DATA_WIDTH-1:0]   operand2;
    logic                    start;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    valid;

    modport master (
        output operand1,
        output operand2,
        output start,
        input  result,
        input  valid
    );

    modport slave (
        input  operand1,
        input  operand2,
        input  start,
        output result,
        output valid
    );
endinterface : multiplier_if
`default_nettype wire

// File: rtl/mult_datapath.sv
`default_nettype none
// ============================================================================
// Module   : mult_datapath
// Purpose  : Radix-2 shift-add datapath. Holds the multiplicand, the upper
//            accumulator half and the multiplier (which doubles as the lower
//            product half). One conditional add plus a right shift per step.
// Ports    : clk, rst      clock, async active-high reset
//            load_i        capture operands and clear accumulator
//            step_i        perform one add/shift iteration
//            mcand_i       multiplicand
//            mplier_i      multiplier
//            product_o     product as it will stand after the current step
// Revision : 1.0  initial release
// ============================================================================
module mult_datapath #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    load_i,
    input  wire logic                    step_i,
    input  wire logic [DATA_WIDTH-1:0]   mcand_i,
    input  wire logic [DATA_WIDTH-1:0]   mplier_i,
    output logic      [2*DATA_WIDTH-1:0] product_o
);
    logic [DATA_WIDTH-1:0] mcand_q,  mcand_d;
    logic [DATA_WIDTH-1:0] acc_q,    acc_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH:0]   sum;

    // One extra bit keeps the adder carry, which shifts into the acc MSB.
    assign sum = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};

    // Exposing the post-step value lets the top capture the final product on
    // the same edge as the last iteration.
    assign product_o = {sum, mplier_q[DATA_WIDTH-1:1]};

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (load_i) begin
            mcand_d  = mcand_i;
            acc_d    = '0;
            mplier_d = mplier_i;
        end else if (step_i) begin
            acc_d    = sum[DATA_WIDTH:1];
            mplier_d = {sum[0], mplier_q[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end
endmodule : mult_datapath
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// Module   : multiplier
// Purpose  : Sequential unsigned multiplier for the MULT/MULTU path. Accepts
//            a request in IDLE, iterates DATA_WIDTH cycles, then registers
//            the product and pulses valid for one cycle.
// Ports    : clk   rising-edge clock
//            rst   async active-high reset, aborts any operation
//            bus   multiplier_if.slave (operands, start, result, valid)
// Revision : 1.0  initial release
// ============================================================================
module multiplier
    import multiplier_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  wire logic   clk,
    input  wire logic   rst,
    multiplier_if.slave bus
);
    localparam int CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

    state_t                  state_q,   state_d;
    logic [CNT_W-1:0]        counter_q, counter_d;
    logic [2*DATA_WIDTH-1:0] result_q,  result_d;
    logic                    valid_q,   valid_d;
    logic                    load;
    logic                    step;
    logic [2*DATA_WIDTH-1:0] product_next;

    mult_datapath #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .step_i    (step),
        .mcand_i   (bus.operand1),
        .mplier_i  (bus.operand2),
        .product_o (product_next)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    counter_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                step      = 1'b1;
                counter_d = counter_q + 1'b1;
                // Final iteration: counter reaches DATA_WIDTH on this edge.
                if (counter_q == LAST_STEP) begin
                    result_d = product_next;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.result = result_q;
    assign bus.valid  = valid_q;
endmodule : multiplier
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier
// Purpose  : Directed self-checking bench for the sequential multiplier.
// Revision : 1.0  initial release
// ============================================================================
module tb_multiplier;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    multiplier_if #(.DATA_WIDTH(W)) bus ();

    multiplier #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge right after the accepting edge. Counts negedges
    // until valid is seen; optionally injects a one-cycle start with new
    // operands at step inj_at, and checks result is still prev_res mid-way.
    task automatic wait_valid(input string tag, input int exp_n,
                              input logic [63:0] exp_res, input logic [63:0] prev_res,
                              input int inj_at, input logic [31:0] ia, input logic [31:0] ib);
        int n;
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == inj_at) begin
                bus.operand1 = ia;
                bus.operand2 = ib;
                bus.start    = 1'b1;
            end else if (inj_at > 0 && i == inj_at + 1) begin
                bus.start = 1'b0;
            end
            if (i == 16 && exp_n > 16)
                chk({tag, "_hold"}, bus.result, prev_res);
            if (bus.valid === 1'b1) begin
                n = i;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_n));
        chk({tag, "_result"}, bus.result, exp_res);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.operand1 = a;
        bus.operand2 = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(bus.valid), 64'd0);
        chk("reset_result", bus.result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 8 x 9, 32-cycle latency, single-cycle pulse
        issue(32'd8, 32'd9);
        wait_valid("p8x9", 32, 64'd72, 64'd0, -1, '0, '0);
        @(negedge clk);
        chk("p8x9_valid_drop", 64'(bus.valid), 64'd0);
        chk("p8x9_result_held", bus.result, 64'd72);

        // all-ones squared exercises the adder carry
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid("pmax", 32, 64'hFFFF_FFFE_0000_0001, 64'd72, -1, '0, '0);

        // zero multiplicand, then identity
        @(negedge clk);
        issue(32'd0, 32'h1234_5678);
        wait_valid("pzero", 32, 64'd0, 64'hFFFF_FFFE_0000_0001, -1, '0, '0);
        @(negedge clk);
        issue(32'h1234_5678, 32'd1);
        wait_valid("pone", 32, 64'h0000_0000_1234_5678, 64'd0, -1, '0, '0);

        // start with new operands 5 cycles into BUSY is ignored
        @(negedge clk);
        issue(32'd6, 32'd7);
        wait_valid("pign", 32, 64'd42, 64'h0000_0000_1234_5678, 5, 32'd9, 32'd9);
        no_valid_for("pign_single_pulse", 40);

        // reset during BUSY aborts at once
        issue(32'd100, 32'd200);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", 64'(bus.valid), 64'd0);
        chk("abort_result", bus.result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        no_valid_for("abort_no_late_valid", 40);

        // back-to-back: start raised during the valid cycle and held high
        issue(32'd2, 32'd5);
        wait_valid("pb2b_first", 32, 64'd10, 64'd0, -1, '0, '0);
        bus.operand1 = 32'd3;
        bus.operand2 = 32'd7;
        bus.start    = 1'b1;
        @(negedge clk);
        wait_valid("pb2b_second", 32, 64'd21, 64'd10, -1, '0, '0);
        wait_valid("pb2b_restart", 33, 64'd21, 64'd21, -1, '0, '0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pb2b_valid_drop", 64'(bus.valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule : tb_multiplier
`default_nettype wire
